disp_scan: RTL

// - Time-multiplexed 4-digit scanner directly upstream of the hex-to-7-segment decoder.
// - Holds a 16-bit hex word, 4 decimal-point bits and 4 blank bits in a shadow register.
// - Each scan slot presents one nibble and its point on hex/point, and a blank flag on le (le=1 blanks the decoder).
// - Drives the matching active-low anode on an[3:0]. A dead-time gap between digits prevents ghosting.

---
 rtl/disp_scan_if.sv | 16 +
 rtl/disp_scan.sv | 96 +++++++++
 2 files changed

// File: rtl/disp_scan_if.sv
// Digit-scanner bus: shadow-load inputs and decoder/anode outputs.
interface disp_scan_if;
    logic        load;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  blanks;
    logic [3:0]  hex;
    logic        point;
    logic        le;
    logic [3:0]  an;

    modport master (output load, hexs, points, blanks,
                    input  hex, point, le, an);
    modport slave  (input  load, hexs, points, blanks,
                    output hex, point, le, an);
endinterface

// File: rtl/disp_scan.sv
// Time-multiplexed 4-digit scanner feeding a hex-to-7-segment decoder, with dead time between digits.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_LZB_EN.
module disp_scan #(
    parameter int SCAN_TICKS = 100000,
    parameter int DEAD_TICKS = 1000
) (
    input  logic         clk,
    input  logic         rst,
    disp_scan_if.slave   dsp
);
    // state   | meaning
    // ST_DEAD | all anodes off between digits, tick counts DEAD_TICKS
    // ST_SHOW | anode of digit idx driven (unless blanked), tick counts SCAN_TICKS
    typedef enum logic {ST_DEAD, ST_SHOW} state_t;

    localparam int MAX_T = (SCAN_TICKS > DEAD_TICKS) ?
                           ((SCAN_TICKS > 2) ? SCAN_TICKS : 2) :
                           ((DEAD_TICKS > 2) ? DEAD_TICKS : 2);
    localparam int TW = $clog2(MAX_T);
    localparam logic [TW-1:0] SHOW_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [TW-1:0] DEAD_LAST = TW'((DEAD_TICKS > 0) ? DEAD_TICKS - 1 : 0);

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [15:0]   hex_q;
    logic [3:0]    pnt_q;
    logic [3:0]    blk_q;
    logic [3:0]    blk_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DEAD;
            idx_q   <= 2'd0;
            tick_q  <= '0;
            hex_q   <= 16'h0000;
            pnt_q   <= 4'h0;
            blk_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            if (dsp.load) begin
                hex_q <= dsp.hexs;
                pnt_q <= dsp.points;
                blk_q <= dsp.blanks;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q + TW'(1);
        case (state_q)
            ST_DEAD: begin
                if (tick_q == DEAD_LAST) begin
                    state_d = ST_SHOW;
                    tick_d  = '0;
                end
            end
            ST_SHOW: begin
                if (tick_q == SHOW_LAST) begin
                    // With no dead time the scan chains straight into the next digit.
                    state_d = (DEAD_TICKS == 0) ? ST_SHOW : ST_DEAD;
                    idx_d   = idx_q + 2'd1;
                    tick_d  = '0;
                end
            end
            default: begin
                state_d = ST_DEAD;
                tick_d  = '0;
            end
        endcase
    end

`ifdef DISP_SCAN_LZB_EN
    logic [3:0] lz;
    // A digit is a leading zero only if it and every digit above it is 0 with no point lit.
    assign lz[3] = (hex_q[15:12] == 4'h0) && !pnt_q[3];
    assign lz[2] = lz[3] && (hex_q[11:8] == 4'h0) && !pnt_q[2];
    assign lz[1] = lz[2] && (hex_q[7:4]  == 4'h0) && !pnt_q[1];
    assign lz[0] = 1'b0;
    assign blk_eff = blk_q | lz;
`else
    assign blk_eff = blk_q;
`endif

    logic lit;
    assign lit = (state_q == ST_SHOW) && !blk_eff[idx_q];

    assign dsp.hex   = hex_q[{idx_q, 2'b00} +: 4];
    assign dsp.point = pnt_q[idx_q];
    assign dsp.le    = !lit;
    assign dsp.an    = lit ? ~(4'b0001 << idx_q) : 4'b1111;
endmodule
